scan_stream_loader: RTL and testbench
=====================================

// Module: scan_stream_loader
// PURPOSE
//  Upstream feeder for controller_top: accepts a 32-bit valid/ready word stream, packs 16 words per
//  512-bit line and writes data lines, then weight lines, into the scan ports (scan_addr,
//  data_mem_scan_in, weight_mem_scan_in) while holding input_mem_scan_mode=1. It then drops scan mode,
//  raises wen to start the convolution, and waits for conv_completed.
// PARAMETERS
//  IN_W      32   stream word width
//  LINE_W    512  scan line width; LINE_W/IN_W = WPL = 16 words per line
//  ADDR_W    8    scan_addr width
// PORTS
//  clk                 in   1       single clock
//  reset_n             in   1       asynchronous active-low reset
//  start               in   1       1-cycle pulse; sampled only in IDLE
//  cfg_data_lines      in   ADDR_W  number of data lines to load (0 = skip)
//  cfg_weight_lines    in   ADDR_W  number of weight lines to load (0 = skip)
//  s_valid             in   1       stream word valid
//  s_data              in   IN_W    stream word
//  s_ready             out  1       loader accepts word when s_valid & s_ready
//  input_mem_scan_mode out  1       1 = memories owned by scan port
//  scan_addr           out  ADDR_W  line address of current write
//  data_mem_scan_in    out  LINE_W  data line
//  weight_mem_scan_in  out  LINE_W  weight line
//  data_we             out  1       1-cycle data-line write strobe
//  weight_we           out  1       1-cycle weight-line write strobe
//  wen                 out  1       convolution enable to controller_top
//  conv_completed      in   1       controller_top finished
//  busy                out  1       state != IDLE
//  done                out  1       1-cycle pulse after conv_completed
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; s_ready=0, input_mem_scan_mode=1, scan_addr=0, line outputs=0,
//   data_we=weight_we=0, wen=0, busy=0, done=0; word/line counters=0. Reset mid-load discards partial line.
//  FSM: IDLE -start-> LOAD_D (cfg_data_lines!=0) | LOAD_W (data=0, weight!=0) | RUN (both 0).
//   LOAD_D -last data line written-> LOAD_W, or RUN if cfg_weight_lines==0.
//   LOAD_W -last weight line written-> RUN.  RUN -conv_completed-> DONE.  DONE -> IDLE (1 cycle).
//  cfg_* latched on start; later changes ignored until next IDLE. start outside IDLE ignored.
//  Packing: word k (0..15) of a line goes to bits [k*IN_W +: IN_W]; word 0 = first accepted.
//  s_ready=1 throughout LOAD_D/LOAD_W, 0 elsewhere; no back-pressure during write (separate output reg).
//  Write latency: cycle after 16th word accepted, line appears on data_mem_scan_in (LOAD_D) or
//   weight_mem_scan_in (LOAD_W) with scan_addr=line index and the matching *_we high exactly 1 cycle;
//   the other line output holds its last value. Lines are 0-based per region (weight restarts at 0).
//  scan_addr wraps modulo 2^ADDR_W (only reachable with cfg=0 never; max lines = 2^ADDR_W-1).
//  Transition LOAD_D->LOAD_W happens on the write cycle; the first weight word may be accepted that cycle.
//  RUN: input_mem_scan_mode=0, wen=1 from RUN entry until the DONE cycle; both restore (1, 0) in DONE.
//  conv_completed outside RUN ignored. Words offered with s_ready=0 are not consumed.
// CONFIGURATION
//  SCAN_LOADER_CHKSUM_EN defined: adds outputs chk_out[IN_W-1:0] (XOR of every accepted word since start,
//   cleared on start and reset) and chk_in[IN_W-1:0] input + chk_err out 1 (set in DONE if chk_out!=chk_in,
//   sticky until next start/reset). Not defined: ports absent, no checksum logic.
// TESTING
//  1) cfg 2/1, stream words 0..47 no gaps -> data_we at addr 0 (line=words 0..15), addr 1 (16..31),
//     weight_we addr 0 (32..47), each 1 cycle after 16th word; then scan_mode=0, wen=1.
//  2) s_valid toggled every other cycle -> same lines/addresses as 1, strobes only on 16th accepted word.
//  3) cfg 0/0, start -> RUN next cycle, wen=1; conv_completed pulse -> done 1 cycle, wen=0, scan_mode=1, IDLE.
//  4) reset_n low after 7 words of line 1 -> all outputs reset values immediately; rerun cfg 1/0 writes addr 0.
//  5) start pulsed during LOAD_D and conv_completed pulsed in LOAD_W -> both ignored, sequence as test 1.
//  6) CHKSUM_EN: words 1..16, chk_in=XOR(1..16)=0x10 -> chk_err=0; chk_in=0 -> chk_err=1 in DONE.

Source files
------------

// File: rtl/scan_stream_loader_if.sv
// Handshake/scan bus between the scan stream loader and its environment.
// SCAN_LOADER_CHKSUM_EN adds the checksum signals (chk_in, chk_out, chk_err).
interface scan_stream_loader_if #(
  parameter int IN_W   = 32,
  parameter int LINE_W = 512,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] cfg_data_lines;
  logic [ADDR_W-1:0] cfg_weight_lines;
  logic              s_valid;
  logic [IN_W-1:0]   s_data;
  logic              s_ready;
  logic              input_mem_scan_mode;
  logic [ADDR_W-1:0] scan_addr;
  logic [LINE_W-1:0] data_mem_scan_in;
  logic [LINE_W-1:0] weight_mem_scan_in;
  logic              data_we;
  logic              weight_we;
  logic              wen;
  logic              conv_completed;
  logic              busy;
  logic              done;
`ifdef SCAN_LOADER_CHKSUM_EN
  logic [IN_W-1:0]   chk_in;
  logic [IN_W-1:0]   chk_out;
  logic              chk_err;

  modport master (
    output start, cfg_data_lines, cfg_weight_lines, s_valid, s_data, conv_completed, chk_in,
    input  s_ready, input_mem_scan_mode, scan_addr, data_mem_scan_in, weight_mem_scan_in,
           data_we, weight_we, wen, busy, done, chk_out, chk_err
  );

  modport slave (
    input  start, cfg_data_lines, cfg_weight_lines, s_valid, s_data, conv_completed, chk_in,
    output s_ready, input_mem_scan_mode, scan_addr, data_mem_scan_in, weight_mem_scan_in,
           data_we, weight_we, wen, busy, done, chk_out, chk_err
  );
`else
  modport master (
    output start, cfg_data_lines, cfg_weight_lines, s_valid, s_data, conv_completed,
    input  s_ready, input_mem_scan_mode, scan_addr, data_mem_scan_in, weight_mem_scan_in,
           data_we, weight_we, wen, busy, done
  );

  modport slave (
    input  start, cfg_data_lines, cfg_weight_lines, s_valid, s_data, conv_completed,
    output s_ready, input_mem_scan_mode, scan_addr, data_mem_scan_in, weight_mem_scan_in,
           data_we, weight_we, wen, busy, done
  );
`endif
endinterface

// File: rtl/scan_stream_loader.sv
// Packs a 32-bit word stream into 512-bit lines, scans data then weight lines in, then runs the conv.
// Optional feature macro: SCAN_LOADER_CHKSUM_EN (XOR checksum of accepted words, checked in DONE).
module scan_stream_loader #(
  parameter int IN_W   = 32,
  parameter int LINE_W = 512,
  parameter int ADDR_W = 8
) (
  input logic                clk,
  input logic                reset_n,
  scan_stream_loader_if.slave bus
);
  localparam int WPL   = LINE_W / IN_W;
  localparam int CNT_W = $clog2(WPL);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_D = 3'd1;
  localparam logic [2:0] S_LOAD_W = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_dataLines;
  logic [ADDR_W-1:0] r_weightLines;
  logic [ADDR_W-1:0] r_lineCnt;
  logic [ADDR_W-1:0] r_scanAddr;
  logic [CNT_W-1:0]  r_wordCnt;
  logic [LINE_W-1:0] r_packBuf;
  logic [LINE_W-1:0] r_dataLine;
  logic [LINE_W-1:0] r_weightLine;
  logic              r_dataWe;
  logic              r_weightWe;

  logic              w_loading;
  logic              w_accept;
  logic              w_lineFull;
  logic              w_lastLine;
  logic [ADDR_W-1:0] w_regionLines;
  logic [LINE_W-1:0] w_fullLine;

  assign w_loading     = (r_state == S_LOAD_D) || (r_state == S_LOAD_W);
  assign w_accept      = w_loading && bus.s_valid;
  assign w_lineFull    = w_accept && (r_wordCnt == CNT_W'(WPL - 1));
  assign w_regionLines = (r_state == S_LOAD_D) ? r_dataLines : r_weightLines;
  assign w_lastLine    = (r_lineCnt == (w_regionLines - ADDR_W'(1)));

  // The line being completed includes the word arriving this cycle, so writes need no extra stage.
  always_comb begin
    w_fullLine = r_packBuf;
    w_fullLine[r_wordCnt*IN_W +: IN_W] = bus.s_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_packBuf <= '0;
      r_wordCnt <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_wordCnt <= '0;
    end else if (w_accept) begin
      r_packBuf <= w_fullLine;
      r_wordCnt <= r_wordCnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_dataLines   <= '0;
      r_weightLines <= '0;
      r_lineCnt     <= '0;
      r_scanAddr    <= '0;
      r_dataLine    <= '0;
      r_weightLine  <= '0;
      r_dataWe      <= 1'b0;
      r_weightWe    <= 1'b0;
    end else begin
      r_dataWe   <= 1'b0;
      r_weightWe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dataLines   <= bus.cfg_data_lines;
            r_weightLines <= bus.cfg_weight_lines;
            r_lineCnt     <= '0;
            if (bus.cfg_data_lines != '0)        r_state <= S_LOAD_D;
            else if (bus.cfg_weight_lines != '0) r_state <= S_LOAD_W;
            else                                 r_state <= S_RUN;
          end
        end
        S_LOAD_D, S_LOAD_W: begin
          if (w_lineFull) begin
            r_scanAddr <= r_lineCnt;
            if (r_state == S_LOAD_D) begin
              r_dataLine <= w_fullLine;
              r_dataWe   <= 1'b1;
            end else begin
              r_weightLine <= w_fullLine;
              r_weightWe   <= 1'b1;
            end
            // Weight addresses restart at 0, so the line counter clears at each region end.
            if (w_lastLine) begin
              r_lineCnt <= '0;
              r_state   <= (r_state == S_LOAD_D && r_weightLines != '0) ? S_LOAD_W : S_RUN;
            end else begin
              r_lineCnt <= r_lineCnt + ADDR_W'(1);
            end
          end
        end
        S_RUN:   if (bus.conv_completed) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.s_ready             = w_loading;
  assign bus.input_mem_scan_mode = (r_state != S_RUN);
  assign bus.wen                 = (r_state == S_RUN);
  assign bus.busy                = (r_state != S_IDLE);
  assign bus.done                = (r_state == S_DONE);
  assign bus.scan_addr           = r_scanAddr;
  assign bus.data_mem_scan_in    = r_dataLine;
  assign bus.weight_mem_scan_in  = r_weightLine;
  assign bus.data_we             = r_dataWe;
  assign bus.weight_we           = r_weightWe;

`ifdef SCAN_LOADER_CHKSUM_EN
  logic [IN_W-1:0] r_chk;
  logic            r_chkErr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chk    <= '0;
      r_chkErr <= 1'b0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_chk    <= '0;
      r_chkErr <= 1'b0;
    end else begin
      if (w_accept) r_chk <= r_chk ^ bus.s_data;
      if (r_state == S_DONE && r_chk != bus.chk_in) r_chkErr <= 1'b1;
    end
  end

  assign bus.chk_out = r_chk;
  assign bus.chk_err = r_chkErr;
`endif
endmodule

// File: tb/tb_scan_stream_loader.sv
// Self-checking bench for scan_stream_loader: word-count based reference model plus directed literal checks.
// Define SCAN_LOADER_CHKSUM_EN to also exercise the checksum outputs.
`timescale 1ns/1ps
module tb_scan_stream_loader;
  localparam int IN_W   = 32;
  localparam int LINE_W = 512;
  localparam int ADDR_W = 8;
  localparam int WPL    = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  scan_stream_loader_if #(.IN_W(IN_W), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus();

  scan_stream_loader #(.IN_W(IN_W), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checksRun    = 0;
  int checksPassed = 0;

  task automatic checkOutput(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checksRun++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the loader is described by how many words it has taken out of how many it needs.
  int                mAcc       = 0;
  int                mTotal     = 0;
  int                mDataCfg   = 0;
  logic              mBusy      = 1'b0;
  logic              mDoneCyc   = 1'b0;
  logic              mDataWe    = 1'b0;
  logic              mWeightWe  = 1'b0;
  logic [ADDR_W-1:0] mAddr      = '0;
  logic [LINE_W-1:0] mDataLine  = '0;
  logic [LINE_W-1:0] mWeightLine = '0;
  logic [IN_W-1:0]   mChk       = '0;
  logic              mChkErr    = 1'b0;
  logic [IN_W-1:0]   mWords[$];
  logic              expReady;
  logic              expWen;

  assign expReady = mBusy && (mAcc < mTotal);
  assign expWen   = mBusy && (mAcc == mTotal) && !mDoneCyc;

  function automatic logic [LINE_W-1:0] lineOf(input int n);
    logic [LINE_W-1:0] l;
    l = '0;
    for (int k = 0; k < WPL; k++) l[k*IN_W +: IN_W] = mWords[n*WPL + k];
    return l;
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    int n;
    if (!reset_n) begin
      mAcc <= 0; mTotal <= 0; mDataCfg <= 0; mBusy <= 1'b0; mDoneCyc <= 1'b0;
      mDataWe <= 1'b0; mWeightWe <= 1'b0; mAddr <= '0; mDataLine <= '0; mWeightLine <= '0;
      mChk <= '0; mChkErr <= 1'b0;
      mWords.delete();
    end else begin
      mDataWe   <= 1'b0;
      mWeightWe <= 1'b0;
      if (!mBusy) begin
        if (bus.start) begin
          mBusy    <= 1'b1;
          mAcc     <= 0;
          mDataCfg <= int'(bus.cfg_data_lines);
          mTotal   <= WPL * (int'(bus.cfg_data_lines) + int'(bus.cfg_weight_lines));
          mChk     <= '0;
          mChkErr  <= 1'b0;
          mWords.delete();
        end
      end else if (mDoneCyc) begin
        mBusy    <= 1'b0;
        mDoneCyc <= 1'b0;
`ifdef SCAN_LOADER_CHKSUM_EN
        if (mChk != bus.chk_in) mChkErr <= 1'b1;
`endif
      end else if (expReady && bus.s_valid) begin
        mWords.push_back(bus.s_data);
        mChk <= mChk ^ bus.s_data;
        mAcc <= mAcc + 1;
        if ((mAcc + 1) % WPL == 0) begin
          n = (mAcc + 1) / WPL - 1;
          if (n < mDataCfg) begin
            mDataWe   <= 1'b1;
            mAddr     <= ADDR_W'(n);
            mDataLine <= lineOf(n);
          end else begin
            mWeightWe   <= 1'b1;
            mAddr       <= ADDR_W'(n - mDataCfg);
            mWeightLine <= lineOf(n);
          end
        end
      end else if (expWen && bus.conv_completed) begin
        mDoneCyc <= 1'b1;
      end
    end
  end

  // Every cycle, mid-period, every output is compared against the model.
  always @(negedge clk) begin
    checkOutput("s_ready",   bus.s_ready, expReady);
    checkOutput("scan_mode", bus.input_mem_scan_mode, !expWen);
    checkOutput("wen",       bus.wen, expWen);
    checkOutput("busy",      bus.busy, mBusy);
    checkOutput("done",      bus.done, mDoneCyc);
    checkOutput("data_we",   bus.data_we, mDataWe);
    checkOutput("weight_we", bus.weight_we, mWeightWe);
    checkOutput("scan_addr", bus.scan_addr, mAddr);
    checkOutput("data_line", bus.data_mem_scan_in, mDataLine);
    checkOutput("wt_line",   bus.weight_mem_scan_in, mWeightLine);
`ifdef SCAN_LOADER_CHKSUM_EN
    checkOutput("chk_out",   bus.chk_out, mChk);
    checkOutput("chk_err",   bus.chk_err, mChkErr);
`endif
  end

  // Strobe log used by the literal expectations.
  logic [ADDR_W-1:0] dAddrLog[$];
  logic [LINE_W-1:0] dLineLog[$];
  logic [ADDR_W-1:0] wAddrLog[$];
  logic [LINE_W-1:0] wLineLog[$];

  always @(negedge clk) begin
    if (bus.data_we) begin
      dAddrLog.push_back(bus.scan_addr);
      dLineLog.push_back(bus.data_mem_scan_in);
    end
    if (bus.weight_we) begin
      wAddrLog.push_back(bus.scan_addr);
      wLineLog.push_back(bus.weight_mem_scan_in);
    end
  end

  task automatic clearLogs();
    dAddrLog.delete(); dLineLog.delete(); wAddrLog.delete(); wLineLog.delete();
  endtask

  task automatic pulseStart(input int d, input int w);
    @(posedge clk); #1;
    bus.cfg_data_lines   = ADDR_W'(d);
    bus.cfg_weight_lines = ADDR_W'(w);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic applyStimulus(input int base, input int n, input bit gaps);
    int  i     = 0;
    int  guard = 0;
    bit  phase = 1'b0;
    while (i < n && guard < 400) begin
      if (gaps && phase) begin
        bus.s_valid = 1'b0;
      end else begin
        bus.s_valid = 1'b1;
        bus.s_data  = IN_W'(base + i);
      end
      if (bus.s_valid && expReady) i++;
      phase = ~phase;
      @(posedge clk); #1;
      guard++;
    end
    bus.s_valid = 1'b0;
    checkOutput("words_sent", LINE_W'(i), LINE_W'(n));
  endtask

  task automatic finishRun();
    int k = 0;
    @(posedge clk); #1;
    bus.conv_completed = 1'b1;
    @(posedge clk); #1;
    bus.conv_completed = 1'b0;
    while (!bus.done && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("done_seen", bus.done, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic checkLogWord(input string name, input int which, input int idx, input int word, input int exp);
    logic [LINE_W-1:0] l;
    l = '0;
    if (which == 0 && idx < dLineLog.size()) l = dLineLog[idx];
    if (which == 1 && idx < wLineLog.size()) l = wLineLog[idx];
    checkOutput(name, l[word*IN_W +: IN_W], LINE_W'(exp));
  endtask

  task automatic checkTwoOneLines(input string tag, input int base);
    checkOutput({tag, "_d_count"}, LINE_W'(dAddrLog.size()), LINE_W'(2));
    checkOutput({tag, "_w_count"}, LINE_W'(wAddrLog.size()), LINE_W'(1));
    if (dAddrLog.size() == 2) begin
      checkOutput({tag, "_d_addr0"}, dAddrLog[0], 0);
      checkOutput({tag, "_d_addr1"}, dAddrLog[1], 1);
    end
    if (wAddrLog.size() == 1) checkOutput({tag, "_w_addr0"}, wAddrLog[0], 0);
    checkLogWord({tag, "_d0_w0"},  0, 0, 0,  base + 0);
    checkLogWord({tag, "_d0_w15"}, 0, 0, 15, base + 15);
    checkLogWord({tag, "_d1_w0"},  0, 1, 0,  base + 16);
    checkLogWord({tag, "_w0_w0"},  1, 0, 0,  base + 32);
    checkLogWord({tag, "_w0_w15"}, 1, 0, 15, base + 47);
  endtask

  initial begin
    bus.start = 1'b0; bus.cfg_data_lines = '0; bus.cfg_weight_lines = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.conv_completed = 1'b0;
`ifdef SCAN_LOADER_CHKSUM_EN
    bus.chk_in = '0;
`endif
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_s_ready", bus.s_ready, 1'b0);
    checkOutput("rst_mode",    bus.input_mem_scan_mode, 1'b1);
    checkOutput("rst_busy",    bus.busy, 1'b0);
    reset_n = 1'b1;

    // 1) cfg 2/1, continuous stream; cfg changes after start must be ignored
    $display("[TB] test 1: cfg 2/1 continuous stream");
    clearLogs();
    pulseStart(2, 1);
    bus.cfg_data_lines = '0; bus.cfg_weight_lines = '0;
    applyStimulus(0, 48, 1'b0);
    checkOutput("t1_wen",  bus.wen, 1'b1);
    checkOutput("t1_mode", bus.input_mem_scan_mode, 1'b0);
    finishRun();
    checkTwoOneLines("t1", 0);

    // 2) valid toggled every other cycle
    $display("[TB] test 2: gapped stream");
    clearLogs();
    pulseStart(2, 1);
    applyStimulus(1000, 48, 1'b1);
    finishRun();
    checkTwoOneLines("t2", 1000);

    // 3) nothing to load: straight to RUN
    $display("[TB] test 3: cfg 0/0");
    pulseStart(0, 0);
    checkOutput("t3_wen",   bus.wen, 1'b1);
    checkOutput("t3_mode",  bus.input_mem_scan_mode, 1'b0);
    checkOutput("t3_ready", bus.s_ready, 1'b0);
    bus.conv_completed = 1'b1;
    @(posedge clk); #1;
    bus.conv_completed = 1'b0;
    checkOutput("t3_done",      bus.done, 1'b1);
    checkOutput("t3_done_wen",  bus.wen, 1'b0);
    checkOutput("t3_done_mode", bus.input_mem_scan_mode, 1'b1);
    @(posedge clk); #1;
    checkOutput("t3_idle_done", bus.done, 1'b0);
    checkOutput("t3_idle_busy", bus.busy, 1'b0);

    // 4) asynchronous reset mid-line, then a clean single-line load
    $display("[TB] test 4: reset mid-load");
    pulseStart(2, 0);
    applyStimulus(200, 23, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("t4_ready",  bus.s_ready, 1'b0);
    checkOutput("t4_mode",   bus.input_mem_scan_mode, 1'b1);
    checkOutput("t4_busy",   bus.busy, 1'b0);
    checkOutput("t4_dline",  bus.data_mem_scan_in, '0);
    checkOutput("t4_addr",   bus.scan_addr, '0);
    checkOutput("t4_dwe",    bus.data_we, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    clearLogs();
    pulseStart(1, 0);
    applyStimulus(300, 16, 1'b0);
    finishRun();
    checkOutput("t4_d_count", LINE_W'(dAddrLog.size()), LINE_W'(1));
    if (dAddrLog.size() == 1) checkOutput("t4_d_addr0", dAddrLog[0], 0);
    checkLogWord("t4_d0_w0", 0, 0, 0, 300);
    checkLogWord("t4_d0_w6", 0, 0, 6, 306);
    checkLogWord("t4_d0_w15", 0, 0, 15, 315);

    // 5) stray start in LOAD_D and stray conv_completed in LOAD_W
    $display("[TB] test 5: ignored start/conv_completed during load");
    clearLogs();
    pulseStart(2, 1);
    fork
      applyStimulus(0, 48, 1'b0);
      begin
        repeat (10) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (26) @(posedge clk);
        #1 bus.conv_completed = 1'b1;
        @(posedge clk); #1 bus.conv_completed = 1'b0;
      end
    join
    checkOutput("t5_wen", bus.wen, 1'b1);
    finishRun();
    checkTwoOneLines("t5", 0);

`ifdef SCAN_LOADER_CHKSUM_EN
    // 6) checksum match then mismatch
    $display("[TB] test 6: checksum");
    bus.chk_in = 32'h10;
    pulseStart(1, 0);
    applyStimulus(1, 16, 1'b0);
    checkOutput("t6_chk_out", bus.chk_out, 32'h10);
    finishRun();
    checkOutput("t6_err_ok", bus.chk_err, 1'b0);
    bus.chk_in = '0;
    pulseStart(1, 0);
    applyStimulus(1, 16, 1'b0);
    finishRun();
    checkOutput("t6_err_bad", bus.chk_err, 1'b1);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end
endmodule
